int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 120 ++++++++++++
 tb/tb_int_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller with lowest-index priority, mask register and REQ/ACK handshake.
// Optional macro INT_CTRL_SYNC_EN inserts a 2-flop synchroniser on every irq line.
module int_ctrl #(
  parameter int          NSRC     = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0008
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            inta,
  output logic            intr,
  output logic [31:0]     vector,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t            r_state, w_state_next;
  logic [IDW-1:0]    r_id, w_id_next, w_grant_id;
  logic              r_intr, w_intr_next;
  logic [31:0]       r_vector, w_vector_next;
  logic [NSRC-1:0]   r_pending, r_mask, r_irq_q;
  logic [NSRC-1:0]   w_irq_s, w_rise, w_req, w_clr;
  logic [1:0]        r_arm_cnt;
  logic              w_armed;

`ifdef INT_CTRL_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [NSRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign w_irq_s = irq;
`endif

  // Edges are blanked until the sampling pipeline has caught up with the live
  // irq levels, so a line already high at reset release never raises a request.
  assign w_armed = (r_arm_cnt == ARM_CYC);
  assign w_rise  = w_armed ? (w_irq_s & ~r_irq_q) : '0;
  assign w_req   = r_pending & ~r_mask;
  assign w_clr   = (r_state == S_REQ && inta) ? (NSRC'(1) << r_id) : '0;

  always_comb begin
    w_grant_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_grant_id = IDW'(i);
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_req) w_state_next = S_REQ;
      S_REQ:   if (inta)   w_state_next = S_ACK;
      S_ACK:   if (!inta)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Id and vector only move on the IDLE->REQ transition; they hold otherwise.
  always_comb begin
    w_intr_next   = (w_state_next == S_REQ);
    w_id_next     = r_id;
    w_vector_next = r_vector;
    if (r_state == S_IDLE && (|w_req)) begin
      w_id_next     = w_grant_id;
      w_vector_next = VEC_BASE + (32'(w_grant_id) << 2);
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_intr    <= 1'b0;
      r_vector  <= VEC_BASE;
      r_id      <= '0;
      r_pending <= '0;
      r_mask    <= '1;
      r_irq_q   <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_intr    <= w_intr_next;
      r_vector  <= w_vector_next;
      r_id      <= w_id_next;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_irq_q   <= w_irq_s;
      if (mask_we) r_mask <= mask_wdata;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  assign intr    = r_intr;
  assign vector  = r_vector;
  assign pending = r_pending;
  assign mask    = r_mask;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expectations queued on a scoreboard, compared with immediate assertions.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        Clk = 1'b0;
  logic        Clrn = 1'b1;
  logic [3:0]  irq = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic        inta = 1'b0;
  logic        intr;
  logic [31:0] vector;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int checks = 0;
  int errors = 0;

  string       q_tag[$];
  logic        q_intr[$];
  logic [31:0] q_vec[$];
  logic [3:0]  q_pend[$];
  logic [3:0]  q_mask[$];

  int_ctrl #(.NSRC(4), .VEC_BASE(32'h0000_0008)) dut (
    .Clk(Clk), .Clrn(Clrn), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .inta(inta), .intr(intr), .vector(vector), .pending(pending), .mask(mask)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n = 1);
    for (int s = 0; s < n; s++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_intr, input logic [31:0] e_vec,
                            input logic [3:0] e_pend, input logic [3:0] e_mask);
    q_tag.push_back(tag);
    q_intr.push_back(e_intr);
    q_vec.push_back(e_vec);
    q_pend.push_back(e_pend);
    q_mask.push_back(e_mask);
  endtask

  task automatic check_out();
    string       t;
    logic        ei;
    logic [31:0] ev;
    logic [3:0]  ep, em;
    while (q_tag.size() > 0) begin
      t  = q_tag.pop_front();
      ei = q_intr.pop_front();
      ev = q_vec.pop_front();
      ep = q_pend.pop_front();
      em = q_mask.pop_front();
      checks++;
      assert (intr === ei) else begin
        errors++;
        $error("FAIL %s.intr observed %0b expected %0b", t, intr, ei);
      end
      checks++;
      assert (vector === ev) else begin
        errors++;
        $error("FAIL %s.vector observed %h expected %h", t, vector, ev);
      end
      checks++;
      assert (pending === ep) else begin
        errors++;
        $error("FAIL %s.pending observed %b expected %b", t, pending, ep);
      end
      checks++;
      assert (mask === em) else begin
        errors++;
        $error("FAIL %s.mask observed %b expected %b", t, mask, em);
      end
      $display("checked %s intr=%0b vector=%h pending=%b mask=%b", t, intr, vector, pending, mask);
    end
  endtask

  initial begin
    // Asynchronous reset, observed before the first clock edge.
    #2 Clrn = 1'b0;
    #1 expect_out("reset_async", 1'b0, 32'h8, 4'b0000, 4'b1111);
    check_out();
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    step(3);

    // Unmask all, single pulse on irq[2].
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    irq = 4'b0100;
    step(LAT - 1);
    expect_out("irq2_pending", 1'b0, 32'h8, 4'b0100, 4'b0000);
    check_out();
    step();
    expect_out("irq2_grant", 1'b1, 32'h10, 4'b0100, 4'b0000);
    check_out();
    irq = 4'b0000; inta = 1'b1;
    step();
    expect_out("irq2_ack", 1'b0, 32'h10, 4'b0000, 4'b0000);
    check_out();
    inta = 1'b0;
    step(2);
    expect_out("irq2_idle", 1'b0, 32'h10, 4'b0000, 4'b0000);
    check_out();

    // Simultaneous rising edges on sources 1 and 3.
    irq = 4'b1010;
    step(LAT - 1);
    expect_out("dual_pending", 1'b0, 32'h10, 4'b1010, 4'b0000);
    check_out();
    step();
    expect_out("dual_grant1", 1'b1, 32'hC, 4'b1010, 4'b0000);
    check_out();
    irq = 4'b0000; inta = 1'b1;
    step();
    expect_out("dual_ack1", 1'b0, 32'hC, 4'b1000, 4'b0000);
    check_out();
    inta = 1'b0;
    step();
    expect_out("dual_gap", 1'b0, 32'hC, 4'b1000, 4'b0000);
    check_out();
    step();
    expect_out("dual_grant3", 1'b1, 32'h14, 4'b1000, 4'b0000);
    check_out();
    inta = 1'b1;
    step();
    inta = 1'b0;
    step(2);
    expect_out("dual_done", 1'b0, 32'h14, 4'b0000, 4'b0000);
    check_out();

    // Masked source latches pending but stays silent until unmasked.
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    irq = 4'b0001;
    step(LAT + 1);
    expect_out("masked_hold", 1'b0, 32'h14, 4'b0001, 4'b1111);
    check_out();
    irq = 4'b0000;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    expect_out("unmask_edge", 1'b0, 32'h14, 4'b0001, 4'b0000);
    check_out();
    step();
    expect_out("unmask_grant", 1'b1, 32'h8, 4'b0001, 4'b0000);
    check_out();

    // New edge on the granted source lands on the acknowledge edge: set wins.
    irq = 4'b0001;
    step(LAT - 2);
    inta = 1'b1;
    step();
    expect_out("set_wins", 1'b0, 32'h8, 4'b0001, 4'b0000);
    check_out();
    inta = 1'b0;
    step(2);
    expect_out("set_wins_regrant", 1'b1, 32'h8, 4'b0001, 4'b0000);
    check_out();
    inta = 1'b1;
    step();
    inta = 1'b0; irq = 4'b0000;
    step(2);
    expect_out("set_wins_done", 1'b0, 32'h8, 4'b0000, 4'b0000);
    check_out();

    // Level held through acknowledge gives one request only.
    irq = 4'b0010;
    step(LAT);
    expect_out("level_grant", 1'b1, 32'hC, 4'b0010, 4'b0000);
    check_out();
    inta = 1'b1;
    step();
    inta = 1'b0;
    step(5);
    expect_out("level_no_repeat", 1'b0, 32'hC, 4'b0000, 4'b0000);
    check_out();
    irq = 4'b0000;
    step(LAT);
    irq = 4'b0010;
    step(LAT);
    expect_out("level_rearm", 1'b1, 32'hC, 4'b0010, 4'b0000);
    check_out();
    inta = 1'b1;
    step();
    inta = 1'b0;
    step(2);

    // Reset in the middle of a request, sources held high across release.
    irq = 4'b0011;
    step(LAT);
    expect_out("pre_reset_grant", 1'b1, 32'h8, 4'b0001, 4'b0000);
    check_out();
    #2 Clrn = 1'b0;
    #1 expect_out("reset_midreq", 1'b0, 32'h8, 4'b0000, 4'b1111);
    check_out();
    @(negedge Clk);
    Clrn = 1'b1;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    step(6);
    expect_out("post_reset_quiet", 1'b0, 32'h8, 4'b0000, 4'b0000);
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
